// File: rtl/acc_alu_unit.sv
// Accumulator ALU: single-cycle arithmetic/logic/shift ops on AC against R,
// plus a WIDTH-cycle shift-add unsigned multiply with a busy/done handshake.
module acc_alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_INC = 4'h2;
  localparam logic [3:0] OP_CLR = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_ASR = 4'hB;
  localparam logic [3:0] OP_MUL = 4'hC;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc_nxt;
  logic [3:0]           flags_nxt;
  logic                 done_nxt;
  logic [2*WIDTH-1:0]   mcand, mcand_nxt, prod, prod_nxt, partial;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [WIDTH+1:0]     alu_out;   // {C, V, result}

  // Signed overflow of a+b (is_sub=0) or a-b (is_sub=1) given the wrapped result.
  function automatic logic ovf(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [WIDTH-1:0] res, input logic is_sub);
    logic signed [WIDTH-1:0] sa, sb, sr;
    sa = a;
    sb = b;
    sr = res;
    if (is_sub) ovf = ((sa < 0) != (sb < 0)) && ((sr < 0) != (sa < 0));
    else        ovf = ((sa < 0) == (sb < 0)) && ((sr < 0) != (sa < 0));
  endfunction

  function automatic logic [WIDTH+1:0] alu_op(input logic [3:0] code,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             c, v;
    ext = '0;
    res = a;
    c   = 1'b0;
    v   = 1'b0;
    case (code)
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = ovf(a, b, res, 1'b0);
      end
      OP_SUB: begin
        ext = {1'b0, a} - {1'b0, b};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = ovf(a, b, res, 1'b1);
      end
      OP_INC: begin
        ext = {1'b0, a} + {1'b0, ONE};
        res = ext[WIDTH-1:0];
        c   = ext[WIDTH];
        v   = ovf(a, ONE, res, 1'b0);
      end
      OP_CLR: res = '0;
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_LD:  res = b;
      OP_SHL: begin
        res = {a[WIDTH-2:0], 1'b0};
        c   = a[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, a[WIDTH-1:1]};
        c   = a[0];
      end
      OP_ASR: begin
        res = {a[WIDTH-1], a[WIDTH-1:1]};
        c   = a[0];
      end
      default: res = a;
    endcase
    alu_op = {c, v, res};
  endfunction

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] res,
                                          input logic c, input logic v);
    mk_flags = {(res == '0), res[WIDTH-1], c, v};
  endfunction

  assign alu_out = alu_op(op, acc, R);
  assign partial = prod + (mplier[0] ? mcand : '0);
  assign busy    = (state == MUL);

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    flags_nxt  = flags;
    done_nxt   = 1'b0;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    prod_nxt   = prod;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_nxt  = {{WIDTH{1'b0}}, acc};
            mplier_nxt = R;
            prod_nxt   = '0;
            cnt_nxt    = CW'(WIDTH);
            state_nxt  = MUL;
          end else if (op > OP_MUL) begin
            done_nxt = 1'b1;
          end else begin
            acc_nxt   = alu_out[WIDTH-1:0];
            flags_nxt = mk_flags(alu_out[WIDTH-1:0], alu_out[WIDTH+1], alu_out[WIDTH]);
            done_nxt  = 1'b1;
          end
        end
      end
      MUL: begin
        prod_nxt   = partial;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt - CW'(1);
        // Last iteration: commit the low half and flag a nonzero high half as carry.
        if (cnt == CW'(1)) begin
          acc_nxt   = partial[WIDTH-1:0];
          flags_nxt = mk_flags(partial[WIDTH-1:0], |partial[2*WIDTH-1:WIDTH], 1'b0);
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      acc   <= '0;
      flags <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      flags <= flags_nxt;
      done  <= done_nxt;
    end
  end

  // Multiplier working registers are only meaningful in MUL and are re-seeded on entry.
  always_ff @(posedge clk) begin
    mcand  <= mcand_nxt;
    mplier <= mplier_nxt;
    prod   <= prod_nxt;
    cnt    <= cnt_nxt;
  end

endmodule

// File: tb/tb_acc_alu_unit.sv
// Directed bench for acc_alu_unit: an 8-bit and a 16-bit instance sharing clock and reset.
module tb_acc_alu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        s8, s16;
  logic [3:0]  op8, op16;
  logic [7:0]  r8;
  logic [15:0] r16;
  logic        busy8, done8, busy16, done16;
  logic [7:0]  acc8;
  logic [15:0] acc16;
  logic [3:0]  fl8, fl16;
  int          total = 0;
  int          bad = 0;
  int          lat;

  always #5 clk = ~clk;

  acc_alu_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(s8), .op(op8), .R(r8),
    .busy(busy8), .done(done8), .acc(acc8), .flags(fl8)
  );

  acc_alu_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(s16), .op(op16), .R(r16),
    .busy(busy16), .done(done16), .acc(acc16), .flags(fl16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue8(input logic [3:0] o, input logic [7:0] r);
    s8 = 1'b1; op8 = o; r8 = r;
    tick();
    s8 = 1'b0;
  endtask

  task automatic issue16(input logic [3:0] o, input logic [15:0] r);
    s16 = 1'b1; op16 = o; r16 = r;
    tick();
    s16 = 1'b0;
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 40) begin tick(); n++; end
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    while (!done16 && n < 60) begin tick(); n++; end
  endtask

  initial begin
    reset = 1'b0; s8 = 1'b0; s16 = 1'b0;
    op8 = 4'h0; op16 = 4'h0; r8 = '0; r16 = '0;
    tick(); tick();
    chk("rst_acc", acc8, 8'h00);
    chk("rst_flags", fl8, 4'b0000);
    chk("rst_busy_done", {busy8, done8}, 2'b00);
    chk("rst_acc16", acc16, 16'h0000);
    reset = 1'b1;

    // Reset beats a simultaneous start
    issue8(4'h8, 8'h5A);
    chk("load5a", {done8, acc8}, {1'b1, 8'h5A});
    reset = 1'b0; s8 = 1'b1; op8 = 4'h0; r8 = 8'h01;
    tick();
    s8 = 1'b0; reset = 1'b1;
    chk("rst_prio", {done8, fl8, acc8}, {1'b0, 4'b0000, 8'h00});
    issue8(4'hD, 8'hFF);
    chk("nop", {done8, fl8, acc8}, {1'b1, 4'b0000, 8'h00});
    tick();
    chk("done_drop", done8, 1'b0);

    // Arithmetic flags {Z,N,C,V}; back-to-back ops keep done high
    issue8(4'h8, 8'h7F);
    issue8(4'h0, 8'h01);
    chk("add_ovf", {done8, fl8, acc8}, {1'b1, 4'b0101, 8'h80});
    issue8(4'h3, 8'hAA);
    chk("clr", {fl8, acc8}, {4'b1000, 8'h00});
    issue8(4'h1, 8'h01);
    chk("sub_borrow", {done8, fl8, acc8}, {1'b1, 4'b0110, 8'hFF});
    issue8(4'h2, 8'h00);
    chk("inc_wrap", {fl8, acc8}, {4'b1010, 8'h00});
    issue8(4'h8, 8'hF0);
    issue8(4'h6, 8'h3C);
    chk("xor", {fl8, acc8}, {4'b0100, 8'hCC});
    issue8(4'h7, 8'h00);
    chk("not", {fl8, acc8}, {4'b0000, 8'h33});

    // Shifts from 0x81
    issue8(4'h8, 8'h81);
    issue8(4'h9, 8'h00);
    chk("shl", {fl8, acc8}, {4'b0010, 8'h02});
    issue8(4'h8, 8'h81);
    issue8(4'hA, 8'h00);
    chk("shr", {fl8, acc8}, {4'b0010, 8'h40});
    issue8(4'h8, 8'h81);
    issue8(4'hB, 8'h00);
    chk("asr", {fl8, acc8}, {4'b0110, 8'hC0});

    // MUL 0x0D x 0x0B = 0x8F, with starts at k+3 and k+8 that must be ignored
    issue8(4'h8, 8'h0D);
    issue8(4'hC, 8'h0B);
    chk("mul_accept", {busy8, done8, acc8}, {2'b10, 8'h0D});
    for (int i = 1; i <= 7; i++) begin
      if (i == 3) begin s8 = 1'b1; op8 = 4'h0; r8 = 8'h55; end
      tick();
      s8 = 1'b0;
      chk($sformatf("mul_busy%0d", i), {busy8, done8, acc8}, {2'b10, 8'h0D});
    end
    s8 = 1'b1; op8 = 4'h0; r8 = 8'h55;
    tick();
    s8 = 1'b0;
    chk("mul_done", {busy8, done8, fl8, acc8}, {2'b01, 4'b0100, 8'h8F});
    tick();
    chk("mul_after", {busy8, done8, acc8}, {2'b00, 8'h8F});

    // MUL 0x10 x 0x10 = 0x100
    issue8(4'h8, 8'h10);
    issue8(4'hC, 8'h10);
    wait_done8(lat);
    chk("mul_lat8", lat, 8);
    chk("mul_hi", {busy8, fl8, acc8}, {1'b0, 4'b1010, 8'h00});

    // Reset on the 4th edge of a MUL aborts it silently
    issue8(4'h8, 8'h0D);
    issue8(4'hC, 8'h0B);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("mul_abort", {busy8, done8, acc8}, {2'b00, 8'h00});
    tick();
    chk("abort_nodone", {busy8, done8}, 2'b00);
    issue8(4'h8, 8'h03);
    chk("load_after_abort", {done8, acc8}, {1'b1, 8'h03});

    // 16-bit instance
    issue16(4'h8, 16'hFFFF);
    issue16(4'h0, 16'h0001);
    chk("add16", {done16, fl16, acc16}, {1'b1, 4'b1010, 16'h0000});
    issue16(4'h8, 16'h0100);
    issue16(4'hC, 16'h0100);
    chk("mul16_busy", {busy16, acc16}, {1'b1, 16'h0100});
    wait_done16(lat);
    chk("mul16_lat", lat, 16);
    chk("mul16", {busy16, fl16, acc16}, {1'b0, 4'b1010, 16'h0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
